// File: rtl/vga_cube_pkg.sv
// -----------------------------------------------------------------------------
// vga_cube_pkg
// Shared definitions for the line rasteriser:
//   - state_e      : rasteriser FSM states
//   - DEF_COORD_W  : default unsigned coordinate width
//   - DEF_WORK_W   : default signed working width (COORD_W + 2)
//   - work_w()     : working width for an arbitrary coordinate width
// The two extra working bits give one bit for the sign and one bit of headroom,
// so that differences of two unsigned coordinates always fit.
// -----------------------------------------------------------------------------
package vga_cube_pkg;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_WORK_W  = DEF_COORD_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DRAW = 3'd3,
        ST_NEXT = 3'd4
    } state_e;

    function automatic int work_w(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// -----------------------------------------------------------------------------
// line_stepper
// One combinational Bresenham step. Given the current error term, position,
// deltas and step directions, produces the error term and position of the
// next pixel on the line.
// Ports:
//   err_i, x_i, y_i      : current error term and position (signed, W bits)
//   dx_i                 : |x1-x0|            (signed, W bits, >= 0)
//   dy_i                 : -|y1-y0|           (signed, W bits, <= 0)
//   sx_i, sy_i           : +1 or -1           (signed, W bits)
//   err_o, x_o, y_o      : next error term and position
// -----------------------------------------------------------------------------
module line_stepper
    import vga_cube_pkg::*;
#(
    parameter int W = DEF_WORK_W
) (
    input  logic signed [W-1:0] err_i,
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic signed [W-1:0] dx_i,
    input  logic signed [W-1:0] dy_i,
    input  logic signed [W-1:0] sx_i,
    input  logic signed [W-1:0] sy_i,
    output logic signed [W-1:0] err_o,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o
);

    // e2 = 2*err needs one more bit than err; the deltas are sign-extended to
    // the same width so both comparisons are plain signed compares.
    logic signed [W:0] e2;
    logic signed [W:0] dx_ext;
    logic signed [W:0] dy_ext;
    logic              step_x;
    logic              step_y;

    assign e2     = $signed({err_i, 1'b0});
    assign dx_ext = $signed({dx_i[W-1], dx_i});
    assign dy_ext = $signed({dy_i[W-1], dy_i});

    // Both decisions use the error term from before this step.
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    always_comb begin
        err_o = err_i;
        x_o   = x_i;
        y_o   = y_i;
        if (step_x) begin
            err_o = err_o + dy_i;
            x_o   = x_i + sx_i;
        end
        if (step_y) begin
            err_o = err_o + dx_i;
            y_o   = y_i + sy_i;
        end
    end

endmodule

// File: rtl/line_raster.sv
// -----------------------------------------------------------------------------
// line_raster
// Walks line IDs 0..NUM_LINES-1 once per frame, fetches each line's endpoints
// from an external source with SRC_LAT cycles of latency, and emits every
// pixel of the line (Bresenham) over a valid/ready pixel interface.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   start                : begin a frame (only honoured while idle)
//   busy                 : high whenever a frame is in progress
//   done                 : one-cycle pulse at the end of a frame
//   line_id              : line index presented to the endpoint source
//   x0, y0, x1, y1       : endpoints returned for line_id
//   px, py, pix_valid    : pixel being offered to the consumer
//   pix_ready            : consumer accepts the pixel this cycle
// -----------------------------------------------------------------------------
module line_raster
    import vga_cube_pkg::*;
#(
    parameter int NUM_LINES = 12,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int SRC_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [31:0]        line_id,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               pix_valid,
    input  logic               pix_ready
);

    localparam int W     = work_w(COORD_W);
    // REQ lasts SRC_LAT cycles (at least one); the counter runs 0..LAT_LAST.
    localparam int LAT_W = (SRC_LAT > 1) ? $clog2(SRC_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((SRC_LAT > 1) ? SRC_LAT - 1 : 0);
    localparam logic [31:0]      LAST_ID  = 32'(NUM_LINES - 1);
    localparam logic signed [W-1:0] STEP_POS = W'(1);
    localparam logic signed [W-1:0] STEP_NEG = '1;

    // ------------------------------------------------------------------ state
    state_e                state_q, state_d;
    logic [31:0]           line_id_q, line_id_d;
    logic [LAT_W-1:0]      lat_q, lat_d;

    logic signed [W-1:0]   x_q,   x_d;
    logic signed [W-1:0]   y_q,   y_d;
    logic signed [W-1:0]   err_q, err_d;
    logic signed [W-1:0]   dx_q,  dx_d;
    logic signed [W-1:0]   dy_q,  dy_d;
    logic signed [W-1:0]   sx_q,  sx_d;
    logic signed [W-1:0]   sy_q,  sy_d;
    logic [COORD_W-1:0]    xe_q,  xe_d;
    logic [COORD_W-1:0]    ye_q,  ye_d;

    // ------------------------------------------------------- derived signals
    logic                  lat_done;
    logic                  last_line;
    logic                  xfer;
    logic                  at_end;

    logic signed [W-1:0]   ax0, ay0, ax1, ay1;
    logic signed [W-1:0]   ddx, ddy, adx, ady;
    logic signed [W-1:0]   step_err, step_x, step_y;

    assign lat_done  = (lat_q >= LAT_LAST);
    assign last_line = (line_id_q == LAST_ID);
    assign xfer      = (state_q == ST_DRAW) && pix_ready;
    // Position never leaves the unsigned coordinate range, so comparing the
    // zero-extended endpoint against the working register is exact.
    assign at_end    = (x_q == $signed({2'b00, xe_q})) && (y_q == $signed({2'b00, ye_q}));

    // Endpoint set-up arithmetic, only consumed in LOAD.
    assign ax0 = $signed({2'b00, x0});
    assign ay0 = $signed({2'b00, y0});
    assign ax1 = $signed({2'b00, x1});
    assign ay1 = $signed({2'b00, y1});
    assign ddx = ax1 - ax0;
    assign ddy = ay1 - ay0;
    assign adx = ddx[W-1] ? -ddx : ddx;
    assign ady = ddy[W-1] ? -ddy : ddy;

    line_stepper #(
        .W (W)
    ) u_stepper (
        .err_i (err_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .dx_i  (dx_q),
        .dy_i  (dy_q),
        .sx_i  (sx_q),
        .sy_i  (sy_q),
        .err_o (step_err),
        .x_o   (step_x),
        .y_o   (step_y)
    );

    // ------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_REQ;
            ST_REQ:  if (lat_done) state_d = ST_LOAD;
            ST_LOAD:               state_d = ST_DRAW;
            ST_DRAW: if (xfer && at_end) state_d = ST_NEXT;
            ST_NEXT: state_d = last_line ? ST_IDLE : ST_REQ;
            default:               state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------- FSM: outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        pix_valid = (state_q == ST_DRAW);
        done      = (state_q == ST_NEXT) && last_line;
    end

    assign line_id = line_id_q;
    assign px      = x_q[COORD_W-1:0];
    assign py      = y_q[COORD_W-1:0];

    // ------------------------------------------------ datapath next values
    always_comb begin
        line_id_d = line_id_q;
        lat_d     = lat_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    line_id_d = '0;
                    lat_d     = '0;
                end
            end
            ST_REQ: begin
                if (!lat_done) lat_d = lat_q + LAT_W'(1);
            end
            ST_LOAD: begin
                x_d   = ax0;
                y_d   = ay0;
                xe_d  = x1;
                ye_d  = y1;
                dx_d  = adx;
                dy_d  = -ady;
                sx_d  = (ax0 < ax1) ? STEP_POS : STEP_NEG;
                sy_d  = (ay0 < ay1) ? STEP_POS : STEP_NEG;
                err_d = adx - ady;
            end
            ST_DRAW: begin
                // A stalled pixel (pix_ready low) keeps everything as is.
                if (xfer && !at_end) begin
                    x_d   = step_x;
                    y_d   = step_y;
                    err_d = step_err;
                end
            end
            ST_NEXT: begin
                if (!last_line) begin
                    line_id_d = line_id_q + 32'd1;
                    lat_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------ datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_id_q <= '0;
            lat_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            err_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
        end else begin
            line_id_q <= line_id_d;
            lat_q     <= lat_d;
            x_q       <= x_d;
            y_q       <= y_d;
            err_q     <= err_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// -----------------------------------------------------------------------------
// tb_line_raster
// Bench for line_raster (NUM_LINES=12, COORD_W=16, SRC_LAT=1). A table-driven
// endpoint source with one cycle of latency feeds the DUT; a reference model
// expands every table line into its expected pixel list, and a compare process
// checks each accepted pixel, stall stability and the done pulse.
// -----------------------------------------------------------------------------
module tb_line_raster;

    localparam int NL = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b1;
    logic          busy, done, pix_valid;
    logic [31:0]   line_id;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [CW-1:0] px, py;

    always #5 clk = ~clk;

    line_raster #(
        .NUM_LINES (NL),
        .COORD_W   (CW),
        .SRC_LAT   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .line_id   (line_id),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .px        (px),
        .py        (py),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    typedef struct {
        int id;
        int x;
        int y;
        int cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t cap_q[$];
    pix_t mq[$];

    int tx0[NL], ty0[NL], tx1[NL], ty1[NL];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cyc = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Reference line expansion: straight from the stepping rules, one pixel
    // per loop pass until the far endpoint has been emitted.
    task automatic model_line(input int ax0, input int ay0, input int ax1,
                              input int ay1, input int id);
        int x, y, dx, dy, sx, sy, err, e2, guard;
        pix_t p;
        x   = ax0;
        y   = ay0;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        guard = 0;
        while (guard < 200000) begin
            p.id = id; p.x = x; p.y = y; p.cyc = 0;
            mq.push_back(p);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            guard++;
        end
    endtask

    task automatic set_default_table();
        for (int i = 0; i < NL; i++) begin
            tx0[i] = 10 + i;
            ty0[i] = 20 - i;
            tx1[i] = (i * 5) % 13;
            ty1[i] = (i * 7) % 11;
        end
        tx0[3] = 7; ty0[3] = 7; tx1[3] = 7; ty1[3] = 7;
    endtask

    // Endpoint source: data for a line_id appears one cycle after the id.
    // While the DUT is drawing, the endpoint pins carry junk.
    initial begin
        int prev_id;
        prev_id = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pix_valid) begin
                x0 = CW'($urandom); y0 = CW'($urandom);
                x1 = CW'($urandom); y1 = CW'($urandom);
            end else begin
                x0 = CW'(tx0[prev_id]); y0 = CW'(ty0[prev_id]);
                x1 = CW'(tx1[prev_id]); y1 = CW'(ty1[prev_id]);
            end
            prev_id = (line_id < NL) ? int'(line_id) : 0;
        end
    end

    // Consumer readiness: always ready, or the repeating pattern 1,0,0.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                pix_ready = 1'b1;
            end else begin
                pix_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Compare process: every accepted pixel against the model queue.
    initial begin
        bit   pstall, pdone;
        int   ppx, ppy;
        pix_t e, c;
        pstall = 0; pdone = 0; ppx = 0; ppy = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pstall = 0;
                pdone  = 0;
                continue;
            end
            if (pstall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_px", px, ppx);
                chk("stall_py", py, ppy);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("px", px, e.x);
                    chk("py", py, e.y);
                    chk("pix_line_id", line_id, e.id);
                end
                c.id = int'(line_id); c.x = int'(px); c.y = int'(py); c.cyc = cyc;
                cap_q.push_back(c);
            end
            if (done) begin
                done_cnt++;
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_single_cycle", pdone, 0);
                chk("done_line_id", line_id, NL - 1);
            end
            pstall = pix_valid && !pix_ready;
            ppx    = int'(px);
            ppy    = int'(py);
            pdone  = done;
        end
    end

    task automatic load_expected();
        mq.delete();
        for (int i = 0; i < NL; i++) model_line(tx0[i], ty0[i], tx1[i], ty1[i], i);
        exp_q = mq;
        cap_q.delete();
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit poke_start);
        int d0, n;
        load_expected();
        d0 = done_cnt;
        kick();
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(negedge clk);
            n++;
            if (poke_start && n == 20) kick();
        end
        repeat (5) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_line0(input string tag, input int n, input int xs[6], input int ys[6]);
        chk({tag, "_cap_size_ok"}, (cap_q.size() >= n) ? 1 : 0, 1);
        if (cap_q.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_id%0d", tag, i), cap_q[i].id, 0);
                chk($sformatf("%s_x%0d", tag, i), cap_q[i].x, xs[i]);
                chk($sformatf("%s_y%0d", tag, i), cap_q[i].y, ys[i]);
            end
            if (cap_q.size() > n) chk({tag, "_next_line"}, cap_q[n].id, 1);
        end
    endtask

    initial begin
        int hx[6], hy[6], sxv[6], syv[6], rx[6], ry[6];
        int n, cnt3, next_id, d0;
        hx  = '{2, 3, 4, 5, 6, 0};  hy  = '{5, 5, 5, 5, 5, 0};
        sxv = '{0, 0, 1, 1, 2, 2};  syv = '{0, 1, 2, 3, 4, 5};
        rx  = '{5, 4, 3, 2, 1, 0};  ry  = '{3, 2, 2, 1, 1, 0};

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_line_id", line_id, 0);
        chk("rst_px", px, 0);
        chk("rst_py", py, 0);

        // Pin the model with hand-computed lines
        mq.delete(); model_line(0, 0, 2, 5, 0);
        chk("model_steep_len", mq.size(), 6);
        for (int i = 0; i < 6 && i < mq.size(); i++) begin
            chk($sformatf("model_steep_x%0d", i), mq[i].x, sxv[i]);
            chk($sformatf("model_steep_y%0d", i), mq[i].y, syv[i]);
        end
        mq.delete(); model_line(5, 3, 1, 1, 0);
        chk("model_rev_len", mq.size(), 5);
        for (int i = 0; i < 5 && i < mq.size(); i++) begin
            chk($sformatf("model_rev_x%0d", i), mq[i].x, rx[i]);
            chk($sformatf("model_rev_y%0d", i), mq[i].y, ry[i]);
        end
        mq.delete(); model_line(9, 9, 9, 9, 0);
        chk("model_point_len", mq.size(), 1);

        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Horizontal line, always ready, consecutive cycles
        set_default_table();
        tx0[0] = 2; ty0[0] = 5; tx1[0] = 6; ty1[0] = 5;
        run_frame("horiz", 0);
        check_line0("horiz", 5, hx, hy);
        if (cap_q.size() >= 5)
            for (int i = 1; i < 5; i++)
                chk($sformatf("horiz_consecutive%0d", i), cap_q[i].cyc - cap_q[i-1].cyc, 1);

        // Steep line
        set_default_table();
        tx0[0] = 0; ty0[0] = 0; tx1[0] = 2; ty1[0] = 5;
        run_frame("steep", 0);
        check_line0("steep", 6, sxv, syv);

        // Reverse direction
        set_default_table();
        tx0[0] = 5; ty0[0] = 3; tx1[0] = 1; ty1[0] = 1;
        run_frame("rev", 0);
        check_line0("rev", 5, rx, ry);
        if (cap_q.size() >= 5)
            for (int i = 1; i < 5; i++)
                chk($sformatf("rev_x_decreasing%0d", i), (cap_q[i].x < cap_q[i-1].x) ? 1 : 0, 1);

        // Backpressure on the horizontal line
        set_default_table();
        tx0[0] = 2; ty0[0] = 5; tx1[0] = 6; ty1[0] = 5;
        ready_mode = 1;
        run_frame("bp", 0);
        check_line0("bp", 5, hx, hy);
        ready_mode = 0;
        @(negedge clk);

        // Full frame, point line at id 3, stray start while busy
        set_default_table();
        run_frame("full", 1);
        cnt3 = 0; next_id = 0;
        foreach (cap_q[i]) begin
            if (cap_q[i].id == 3) cnt3++;
            if (cap_q[i].id == next_id) next_id++;
        end
        chk("full_point_pixels", cnt3, 1);
        chk("full_ids_walked", next_id, NL);

        // Reset in the middle of drawing line 4
        set_default_table();
        load_expected();
        kick();
        n = 0;
        while (!(pix_valid && line_id == 4) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_line4", (pix_valid && line_id == 4) ? 1 : 0, 1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_pix_valid", pix_valid, 0);
        chk("rst_mid_line_id", line_id, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_stays_idle", busy, 0);
        run_frame("after_rst", 0);
        chk("after_rst_first_id", (cap_q.size() > 0) ? cap_q[0].id : -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
